rs_frame_checker: RTL

Synthesizable in-line protocol and length checker for the RS decoder. It observes the decoder's input and output codeword streams and queues each accepted input frame length in a FIFO of pending frames. Each output frame is checked against its queued length, and an output-latency watchdog runs alongside. Sticky error flags and frame counters are exported for silicon debug and serve as the formal/simulation monitor for decoder variants with different N, K and queue depths.

---
 rtl/rs_frame_checker.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_frame_checker.sv
// Purpose : in-line protocol/length monitor for the RS decoder; pairs input frames with output frames.
// Latency : every flag, counter and occupancy output is registered one cycle after the causing beat.
// Backpress: none; observe-only. Input beats qualify on dec_o_in_ready, output beats on dec_o_valid alone.
//
// Ports:
//   clk, rst                      single clock, synchronous active-low reset
//   dec_i_*                       decoder input strobes (valid/start/end), dec_o_in_ready = decoder accept
//   dec_o_valid/start/end         decoder output strobes
//   chk_err_*                     sticky error flags, cleared only by reset
//   chk_any_err                   registered OR of the sticky flags (one cycle behind them)
//   chk_pending                   number of input frames still waiting for an output frame
//   chk_frames_in/out             wrapping counts of completed input/output frames

// Frame delimiter tracker shared by the input and output sides.
// Counts beats of the current frame (saturating) and flags start/end misuse.
// Outputs are combinational in the beat cycle; the parent registers them.
module rs_frame_len_fsm #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic             sof,
  input  logic             eof,
  output logic             done,
  output logic [LEN_W-1:0] done_len,
  output logic             proto_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n, len_inc;

  // Saturate instead of wrapping so an over-long frame can never alias a legal length.
  assign len_inc = (len == '1) ? len : len + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      len   <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len;
    done      = 1'b0;
    done_len  = len_inc;
    proto_err = 1'b0;
    if (beat) begin
      if (sof) begin
        // A start inside a frame abandons the partial frame and begins a new one.
        proto_err = (state == IN_FRAME);
        if (eof) begin
          done     = 1'b1;
          done_len = LEN_W'(1);
          state_n  = IDLE;
        end else begin
          state_n = IN_FRAME;
          len_n   = LEN_W'(1);
        end
      end else if (state == IDLE) begin
        // Beat outside any frame: dropped.
        proto_err = 1'b1;
      end else if (eof) begin
        done     = 1'b1;
        done_len = len_inc;
        state_n  = IDLE;
      end else begin
        len_n = len_inc;
      end
    end
  end

endmodule

module rs_frame_checker #(
  parameter int WORD_LENGTH  = 8,
  parameter int N            = 15,
  parameter int K            = 11,
  parameter int DEPTH        = 4,
  parameter int OUT_LEN_MODE = 0,
  parameter int MAX_LATENCY  = 64,
  parameter int CNT_W        = 16,
  localparam int LEN_W       = $clog2(N + 2),
  localparam int PEND_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_i_valid,
  input  logic              dec_i_start_codeword,
  input  logic              dec_i_end_codeword,
  input  logic              dec_o_in_ready,
  input  logic              dec_o_valid,
  input  logic              dec_o_start_codeword,
  input  logic              dec_o_end_codeword,
  output logic              chk_err_len,
  output logic              chk_err_range,
  output logic              chk_err_in_proto,
  output logic              chk_err_out_proto,
  output logic              chk_err_overflow,
  output logic              chk_err_underflow,
  output logic              chk_err_timeout,
  output logic              chk_any_err,
  output logic [PEND_W-1:0] chk_pending,
  output logic [CNT_W-1:0]  chk_frames_in,
  output logic [CNT_W-1:0]  chk_frames_out
);

  // A one-entry queue still needs a one-bit pointer that simply stays at zero.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1;
  localparam logic [LEN_W-1:0] PARITY_LEN = LEN_W'(N - K);

  // WORD_LENGTH only documents the symbol width of the observed decoder.
  if (DEPTH < 1 || WORD_LENGTH < 1 || K > N) begin : g_param_check
    $error("rs_frame_checker: DEPTH, WORD_LENGTH must be >= 1 and K <= N");
  end

  logic             in_done, in_proto;
  logic [LEN_W-1:0] in_len;
  logic             out_done, out_proto;
  logic [LEN_W-1:0] out_len;

  rs_frame_len_fsm #(.LEN_W(LEN_W)) u_in_fsm (
    .clk       (clk),
    .rst       (rst),
    .beat      (dec_i_valid & dec_o_in_ready),
    .sof       (dec_i_start_codeword),
    .eof       (dec_i_end_codeword),
    .done      (in_done),
    .done_len  (in_len),
    .proto_err (in_proto)
  );

  rs_frame_len_fsm #(.LEN_W(LEN_W)) u_out_fsm (
    .clk       (clk),
    .rst       (rst),
    .beat      (dec_o_valid),
    .sof       (dec_o_start_codeword),
    .eof       (dec_o_end_codeword),
    .done      (out_done),
    .done_len  (out_len),
    .proto_err (out_proto)
  );

  // Pending-frame queue of input lengths.
  logic [LEN_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PEND_W-1:0] count, count_n;
  logic              fifo_full, fifo_empty;
  logic              push_acc, pop_acc, overflow, underflow;
  logic [LEN_W-1:0]  head, exp_len;
  logic              len_mismatch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count == PEND_W'(DEPTH));
  assign fifo_empty = (count == '0);

  // A pop frees the slot in the same cycle, so a full queue still accepts a
  // concurrent push. A pop from an empty queue cannot see a same-cycle push.
  assign push_acc  = in_done & (~fifo_full | out_done);
  assign pop_acc   = out_done & ~fifo_empty;
  assign overflow  = in_done & fifo_full & ~out_done;
  assign underflow = out_done & fifo_empty;

  // Head is read before this cycle's write, even when wr_ptr == rd_ptr.
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    exp_len = head;
    if (OUT_LEN_MODE == 1) begin
      exp_len = (head > PARITY_LEN) ? head - PARITY_LEN : '0;
    end
  end

  assign len_mismatch = pop_acc & (out_len != exp_len);

  always_comb begin
    count_n = count;
    case ({push_acc, pop_acc})
      2'b10:   count_n = count + PEND_W'(1);
      2'b01:   count_n = count - PEND_W'(1);
      default: count_n = count;
    endcase
  end

  // Data storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      fifo_mem[wr_ptr] <= in_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_n;
    end
  end

  // Latency watchdog: age of the oldest pending frame since the last pop.
  logic [TMR_W-1:0] timer, timer_n;

  always_comb begin
    timer_n = timer;
    if (out_done || fifo_empty) begin
      timer_n = '0;
    end else if (MAX_LATENCY != 0 && timer != TMR_W'(MAX_LATENCY)) begin
      timer_n = timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
    end else begin
      timer <= timer_n;
    end
  end

  // Sticky flags and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_err_len       <= 1'b0;
      chk_err_range     <= 1'b0;
      chk_err_in_proto  <= 1'b0;
      chk_err_out_proto <= 1'b0;
      chk_err_overflow  <= 1'b0;
      chk_err_underflow <= 1'b0;
      chk_err_timeout   <= 1'b0;
      chk_any_err       <= 1'b0;
      chk_frames_in     <= '0;
      chk_frames_out    <= '0;
    end else begin
      if (len_mismatch)                              chk_err_len       <= 1'b1;
      if (in_done && in_len != LEN_W'(N))            chk_err_range     <= 1'b1;
      if (in_proto)                                  chk_err_in_proto  <= 1'b1;
      if (out_proto)                                 chk_err_out_proto <= 1'b1;
      if (overflow)                                  chk_err_overflow  <= 1'b1;
      if (underflow)                                 chk_err_underflow <= 1'b1;
      if (MAX_LATENCY != 0 && timer_n == TMR_W'(MAX_LATENCY)) chk_err_timeout <= 1'b1;
      // Built from the registered flags, so it trails them by one cycle.
      chk_any_err <= chk_err_len | chk_err_range | chk_err_in_proto | chk_err_out_proto |
                     chk_err_overflow | chk_err_underflow | chk_err_timeout;
      if (in_done)  chk_frames_in  <= chk_frames_in + CNT_W'(1);
      if (out_done) chk_frames_out <= chk_frames_out + CNT_W'(1);
    end
  end

  assign chk_pending = count;

endmodule
